quiz_round_ctrl: RTL and testbench

//  Sequences one quiz round for the responder game: arms the answer window on the host's start

---
 rtl/quiz_pkg.sv | 31 +++
 rtl/edge_det.sv | 23 ++
 rtl/quiz_round_ctrl.sv | 160 ++++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz round controller: state codes,
// build defaults and saturating score arithmetic.
package quiz_pkg;

    localparam int N_PLAYERS   = 4;
    localparam int TIME_W_DEF  = 8;
    localparam int SCORE_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_JUDGE = 3'd2,
        ST_SCORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Operands arrive zero-extended to 32 bits; callers size the result back down.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector: remembers the previous input level and
// flags bits that were low last cycle and are high now.
module edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst)
            prev <= '0;
        else
            prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/quiz_round_ctrl.sv
// One quiz round: arm the answer window, count it down, grant the first enabled buzzer,
// apply the host verdict to that player's score. Define FOUL_DETECT_EN to penalise early presses.
module quiz_round_ctrl #(
    parameter int N_PLAYERS = quiz_pkg::N_PLAYERS,
    parameter int TICK_DIV  = 50000000,
    parameter int TIME_W    = quiz_pkg::TIME_W_DEF,
    parameter int SCORE_W   = quiz_pkg::SCORE_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_PLAYERS-1:0]           player,
    input  logic                           yes,
    input  logic                           no,
    input  logic [TIME_W-1:0]              maxtime,
    input  logic [2:0]                     maxuser,
    input  logic [SCORE_W-1:0]             scorejia,
    input  logic [SCORE_W-1:0]             scorejian,
    output logic [N_PLAYERS-1:0]           who,
    output logic [TIME_W-1:0]              resttime,
    output logic [2:0]                     state_o,
    output logic [N_PLAYERS*SCORE_W-1:0]   scores,
    output logic                           timeout,
    output logic [N_PLAYERS-1:0]           foul
);

    import quiz_pkg::*;

    localparam int IDX_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

    logic                 start_rise;
    logic                 yes_rise;
    logic                 no_rise;
    logic [N_PLAYERS-1:0] player_rise;

    state_t               state;
    logic [TICK_W-1:0]    tick;
    logic [SCORE_W-1:0]   score_r [N_PLAYERS];
    logic [IDX_W-1:0]     win_idx;
    logic                 verdict_yes;

    int                   eff_users;
    logic [N_PLAYERS-1:0] enabled;
    logic [N_PLAYERS-1:0] grant;
    logic [N_PLAYERS-1:0] grant_onehot;
    logic [IDX_W-1:0]     grant_idx;

    edge_det #(.W(1)) u_start_edge (.clk(clk), .rst(rst), .d(start), .rise(start_rise));
    edge_det #(.W(1)) u_yes_edge   (.clk(clk), .rst(rst), .d(yes),   .rise(yes_rise));
    edge_det #(.W(1)) u_no_edge    (.clk(clk), .rst(rst), .d(no),    .rise(no_rise));
    edge_det #(.W(N_PLAYERS)) u_player_edge (.clk(clk), .rst(rst), .d(player), .rise(player_rise));

    // maxuser of 0 (or anything past the player count) enables every buzzer.
    always_comb begin
        eff_users = (maxuser == 3'd0 || int'(maxuser) > N_PLAYERS) ? N_PLAYERS : int'(maxuser);
        for (int i = 0; i < N_PLAYERS; i++)
            enabled[i] = (i < eff_users);
        grant        = player_rise & enabled;
        grant_onehot = grant & (~grant + N_PLAYERS'(1));
        grant_idx    = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--)
            if (grant[i])
                grant_idx = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            who         <= '0;
            resttime    <= '0;
            tick        <= '0;
            win_idx     <= '0;
            verdict_yes <= 1'b0;
            timeout     <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++)
                score_r[i] <= '0;
`ifdef FOUL_DETECT_EN
            foul        <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state    <= ST_ARMED;
                        resttime <= maxtime;
                        tick     <= '0;
                    end
                end
                // A press beats expiry; the countdown only moves when neither happens.
                ST_ARMED: begin
                    if (|grant) begin
                        who     <= grant_onehot;
                        win_idx <= grant_idx;
                        state   <= ST_JUDGE;
                    end else if (resttime == '0) begin
                        timeout <= 1'b1;
                        who     <= '0;
                        state   <= ST_DONE;
                    end else if (tick == TICK_LAST) begin
                        tick     <= '0;
                        resttime <= resttime - TIME_W'(1);
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                ST_JUDGE: begin
                    if (yes_rise != no_rise) begin
                        verdict_yes <= yes_rise;
                        state       <= ST_SCORE;
                    end
                end
                ST_SCORE: begin
                    if (verdict_yes)
                        score_r[win_idx] <= SCORE_W'(sat_add(32'(score_r[win_idx]),
                                                             32'(scorejia), SCORE_MAX));
                    else
                        score_r[win_idx] <= SCORE_W'(sat_sub(32'(score_r[win_idx]),
                                                             32'(scorejian)));
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (start_rise) begin
                        state    <= ST_ARMED;
                        who      <= '0;
                        resttime <= maxtime;
                        tick     <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef FOUL_DETECT_EN
            // Early presses never touch the state, only the offenders' scores.
            foul <= '0;
            if (state == ST_IDLE || state == ST_DONE) begin
                foul <= grant;
                for (int i = 0; i < N_PLAYERS; i++)
                    if (grant[i])
                        score_r[i] <= SCORE_W'(sat_sub(32'(score_r[i]), 32'(scorejian)));
            end
`endif
        end
    end

`ifndef FOUL_DETECT_EN
    assign foul = '0;
`endif

    assign state_o = state;

    always_comb begin
        scores = '0;
        for (int i = 0; i < N_PLAYERS; i++)
            scores[i*SCORE_W +: SCORE_W] = score_r[i];
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed round scenarios plus randomized rounds
// checked against a score/winner model built from the game rules.
module tb_quiz_round_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, yes, no;
    logic [3:0]  player;
    logic [7:0]  maxtime;
    logic [2:0]  maxuser;
    logic [3:0]  jia, jian;
    logic [3:0]  who, foul;
    logic [7:0]  resttime;
    logic [2:0]  state_o;
    logic [15:0] scores;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int m_score [4];

    quiz_round_ctrl #(.N_PLAYERS(4), .TICK_DIV(10), .TIME_W(8), .SCORE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .player(player), .yes(yes), .no(no),
        .maxtime(maxtime), .maxuser(maxuser), .scorejia(jia), .scorejian(jian),
        .who(who), .resttime(resttime), .state_o(state_o), .scores(scores),
        .timeout(timeout), .foul(foul)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] model_scores();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[i*4 +: 4] = 4'(m_score[i]);
        return v;
    endfunction

    function automatic void model_yes(input int p, input int pts);
        m_score[p] = (m_score[p] + pts > 15) ? 15 : m_score[p] + pts;
    endfunction

    function automatic void model_no(input int p, input int pts);
        m_score[p] = (m_score[p] > pts) ? m_score[p] - pts : 0;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Complete round: start, one press, one verdict; ends in DONE after scoring.
    task automatic run_round(input logic [7:0] mt, input logic [3:0] press, input bit v);
        maxtime = mt;
        start = 1'b1; step(1); start = 1'b0; step(1);
        player = press; step(1); player = 4'b0000;
        if (v) yes = 1'b1; else no = 1'b1;
        step(1);
        yes = 1'b0; no = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; yes = 1'b0; no = 1'b0; player = 4'b0000;
        maxtime = 8'd0; maxuser = 3'd4; jia = 4'd0; jian = 4'd0;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_score[i] = 0;
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL rst_state got=%0d exp=0", state_o); end
        checks++; if (who !== 4'b0000 || resttime !== 8'd0) begin errors++; $display("[TB] FAIL rst_who_rest got who=%b rest=%0d exp who=0000 rest=0", who, resttime); end
        checks++; if (scores !== 16'h0000 || timeout !== 1'b0 || foul !== 4'b0000) begin errors++; $display("[TB] FAIL rst_outs got scores=%h timeout=%b foul=%b exp 0000/0/0000", scores, timeout, foul); end
    endtask

    task automatic test_countdown();
        maxuser = 3'd4; maxtime = 8'd3;
        start = 1'b1; step(1); start = 1'b0;
        checks++; if (state_o !== 3'd1 || resttime !== 8'd3) begin errors++; $display("[TB] FAIL cd_arm got state=%0d rest=%0d exp state=1 rest=3", state_o, resttime); end
        step(9);
        checks++; if (resttime !== 8'd3) begin errors++; $display("[TB] FAIL cd_hold3 got=%0d exp=3", resttime); end
        step(1);
        checks++; if (resttime !== 8'd2) begin errors++; $display("[TB] FAIL cd_rest2 got=%0d exp=2", resttime); end
        step(10);
        checks++; if (resttime !== 8'd1) begin errors++; $display("[TB] FAIL cd_rest1 got=%0d exp=1", resttime); end
        step(10);
        checks++; if (resttime !== 8'd0 || state_o !== 3'd1 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL cd_rest0 got rest=%0d state=%0d to=%b exp 0/1/0", resttime, state_o, timeout); end
        step(1);
        checks++; if (timeout !== 1'b1 || state_o !== 3'd4 || who !== 4'b0000) begin errors++; $display("[TB] FAIL cd_expire got to=%b state=%0d who=%b exp 1/4/0000", timeout, state_o, who); end
        step(1);
        checks++; if (timeout !== 1'b0 || state_o !== 3'd4) begin errors++; $display("[TB] FAIL cd_pulse got to=%b state=%0d exp 0/4", timeout, state_o); end
    endtask

    task automatic test_simultaneous();
        jia = 4'd2; maxtime = 8'd5;
        start = 1'b1; step(1); start = 1'b0; step(2);
        player = 4'b0110; step(1); player = 4'b0000;
        checks++; if (who !== 4'b0010 || state_o !== 3'd2 || resttime !== 8'd5) begin errors++; $display("[TB] FAIL sim_grant got who=%b state=%0d rest=%0d exp 0010/2/5", who, state_o, resttime); end
        yes = 1'b1; step(1); yes = 1'b0;
        checks++; if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL sim_score_state got=%0d exp=3", state_o); end
        step(1);
        model_yes(1, 2);
        checks++; if (scores !== model_scores() || state_o !== 3'd4) begin errors++; $display("[TB] FAIL sim_scores got=%h state=%0d exp=%h state=4", scores, state_o, model_scores()); end
    endtask

    task automatic test_saturation();
        jia = 4'd1; run_round(8'd5, 4'b0100, 1'b1); model_yes(2, 1);
        checks++; if (scores !== model_scores()) begin errors++; $display("[TB] FAIL sat_setup got=%h exp=%h", scores, model_scores()); end
        jian = 4'd3; run_round(8'd5, 4'b0100, 1'b0); model_no(2, 3);
        checks++; if (scores[11:8] !== 4'd0 || scores !== model_scores()) begin errors++; $display("[TB] FAIL sat_floor got=%h exp=%h", scores, model_scores()); end
        jia = 4'd14; run_round(8'd5, 4'b1000, 1'b1); model_yes(3, 14);
        jia = 4'd5;  run_round(8'd5, 4'b1000, 1'b1); model_yes(3, 5);
        checks++; if (scores[15:12] !== 4'd15 || scores !== model_scores()) begin errors++; $display("[TB] FAIL sat_ceiling got=%h exp=%h", scores, model_scores()); end
    endtask

    task automatic test_maxuser_expiry();
        maxuser = 3'd2; maxtime = 8'd5; jian = 4'd1;
        start = 1'b1; step(1); start = 1'b0;
        player = 4'b0100; step(1); player = 4'b0000;
        checks++; if (who !== 4'b0000 || state_o !== 3'd1) begin errors++; $display("[TB] FAIL mu_ignore got who=%b state=%0d exp 0000/1", who, state_o); end
        step(1);
        player = 4'b0001; step(1); player = 4'b0000;
        checks++; if (who !== 4'b0001 || state_o !== 3'd2) begin errors++; $display("[TB] FAIL mu_grant got who=%b state=%0d exp 0001/2", who, state_o); end
        no = 1'b1; step(1); no = 1'b0; step(1); model_no(0, 1);
        checks++; if (scores !== model_scores()) begin errors++; $display("[TB] FAIL mu_scores got=%h exp=%h", scores, model_scores()); end
        maxuser = 3'd4; maxtime = 8'd1; jia = 4'd3;
        start = 1'b1; step(1); start = 1'b0; step(10);
        checks++; if (resttime !== 8'd0 || state_o !== 3'd1) begin errors++; $display("[TB] FAIL exp_edge got rest=%0d state=%0d exp 0/1", resttime, state_o); end
        player = 4'b0010; step(1); player = 4'b0000;
        checks++; if (who !== 4'b0010 || state_o !== 3'd2 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL exp_press got who=%b state=%0d to=%b exp 0010/2/0", who, state_o, timeout); end
        step(15);
        checks++; if (state_o !== 3'd2 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL judge_no_timeout got state=%0d to=%b exp 2/0", state_o, timeout); end
        yes = 1'b1; no = 1'b1; step(1); yes = 1'b0; no = 1'b0;
        checks++; if (state_o !== 3'd2) begin errors++; $display("[TB] FAIL both_verdicts got state=%0d exp=2", state_o); end
        step(1); yes = 1'b1; step(1); yes = 1'b0; step(1); model_yes(1, 3);
        checks++; if (scores !== model_scores() || state_o !== 3'd4) begin errors++; $display("[TB] FAIL exp_scores got=%h state=%0d exp=%h state=4", scores, state_o, model_scores()); end
        maxtime = 8'd0;
        start = 1'b1; step(1); start = 1'b0;
        checks++; if (state_o !== 3'd1 || resttime !== 8'd0 || who !== 4'b0000) begin errors++; $display("[TB] FAIL zero_arm got state=%0d rest=%0d who=%b exp 1/0/0000", state_o, resttime, who); end
        step(1);
        checks++; if (timeout !== 1'b1 || state_o !== 3'd4) begin errors++; $display("[TB] FAIL zero_expire got to=%b state=%0d exp 1/4", timeout, state_o); end
    endtask

    task automatic test_back_to_back();
        jia = 4'd1; jian = 4'd2;
        run_round(8'd5, 4'b0100, 1'b1); model_yes(2, 1);
        checks++; if (who !== 4'b0100 || state_o !== 3'd4) begin errors++; $display("[TB] FAIL b2b_hold got who=%b state=%0d exp 0100/4", who, state_o); end
        start = 1'b1; step(1); start = 1'b0;
        checks++; if (who !== 4'b0000 || state_o !== 3'd1 || resttime !== 8'd5) begin errors++; $display("[TB] FAIL b2b_rearm got who=%b state=%0d rest=%0d exp 0000/1/5", who, state_o, resttime); end
        step(1); start = 1'b1; step(1); start = 1'b0;
        checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL b2b_start_armed got state=%0d exp=1", state_o); end
        player = 4'b0001; step(1); player = 4'b0000; step(1);
        player = 4'b0010; start = 1'b1; step(1); player = 4'b0000; start = 1'b0;
        checks++; if (who !== 4'b0001 || state_o !== 3'd2) begin errors++; $display("[TB] FAIL b2b_judge_hold got who=%b state=%0d exp 0001/2", who, state_o); end
        no = 1'b1; step(1); no = 1'b0; step(1); model_no(0, 2);
        checks++; if (scores !== model_scores() || state_o !== 3'd4) begin errors++; $display("[TB] FAIL b2b_scores got=%h state=%0d exp=%h state=4", scores, state_o, model_scores()); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            int mu, eff, mt, k, d, w;
            bit v;
            logic [3:0] press;
            mu  = $urandom_range(0, 7);
            eff = (mu == 0 || mu > 4) ? 4 : mu;
            mt  = $urandom_range(1, 3);
            k   = $urandom_range(0, eff - 1);
            d   = $urandom_range(0, 5);
            v   = 1'($urandom_range(0, 1));
            press = 4'($urandom_range(0, 15)) | 4'(1 << k);
            w = -1;
            for (int i = 0; i < 4; i++)
                if (w < 0 && press[i] && i < eff) w = i;
            maxuser = 3'(mu); maxtime = 8'(mt);
            jia = 4'($urandom_range(0, 15)); jian = 4'($urandom_range(0, 15));
            start = 1'b1; step(1); start = 1'b0;
            step(d);
            player = press; step(1); player = 4'b0000;
            checks++; if (who !== 4'(1 << w) || state_o !== 3'd2 || resttime !== 8'(mt)) begin errors++; $display("[TB] FAIL rnd%0d_grant got who=%b state=%0d rest=%0d exp who=%b state=2 rest=%0d", r, who, state_o, resttime, 4'(1 << w), mt); end
            if (v) yes = 1'b1; else no = 1'b1;
            step(1); yes = 1'b0; no = 1'b0; step(1);
            if (v) model_yes(w, int'(jia)); else model_no(w, int'(jian));
            checks++; if (scores !== model_scores() || state_o !== 3'd4) begin errors++; $display("[TB] FAIL rnd%0d_score got=%h state=%0d exp=%h state=4", r, scores, state_o, model_scores()); end
        end
    endtask

    task automatic test_reset_mid();
        maxuser = 3'd4;
        maxtime = 8'd5; start = 1'b1; step(1); start = 1'b0;
        player = 4'b0001; step(1); player = 4'b0000;
        checks++; if (state_o !== 3'd2) begin errors++; $display("[TB] FAIL rm_judge got state=%0d exp=2", state_o); end
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < 4; i++) m_score[i] = 0;
        checks++; if (state_o !== 3'd0 || who !== 4'b0000 || scores !== 16'h0000 || resttime !== 8'd0) begin errors++; $display("[TB] FAIL rm_abort got state=%0d who=%b scores=%h rest=%0d exp 0/0000/0000/0", state_o, who, scores, resttime); end
        yes = 1'b1; step(1); yes = 1'b0; step(1);
        checks++; if (state_o !== 3'd0 || scores !== 16'h0000) begin errors++; $display("[TB] FAIL rm_yes_after got state=%0d scores=%h exp 0/0000", state_o, scores); end
    endtask

    task automatic test_foul();
        logic [3:0] exp_foul;
        bit foul_on;
`ifdef FOUL_DETECT_EN
        foul_on = 1'b1;
`else
        foul_on = 1'b0;
`endif
        maxuser = 3'd4; jian = 4'd1;
        player = 4'b0001; step(1); player = 4'b0000;
        exp_foul = foul_on ? 4'b0001 : 4'b0000;
        checks++; if (foul !== exp_foul || state_o !== 3'd0 || scores !== model_scores()) begin errors++; $display("[TB] FAIL foul_idle got foul=%b state=%0d scores=%h exp %b/0/%h", foul, state_o, scores, exp_foul, model_scores()); end
        jia = 4'd2; run_round(8'd5, 4'b0001, 1'b1); model_yes(0, 2);
        jian = 4'd1;
        player = 4'b0001; step(1); player = 4'b0000;
        if (foul_on) model_no(0, 1);
        checks++; if (foul !== exp_foul || state_o !== 3'd4 || scores !== model_scores()) begin errors++; $display("[TB] FAIL foul_done got foul=%b state=%0d scores=%h exp %b/4/%h", foul, state_o, scores, exp_foul, model_scores()); end
        step(1);
        checks++; if (foul !== 4'b0000) begin errors++; $display("[TB] FAIL foul_pulse got=%b exp=0000", foul); end
        jia = 4'd4; run_round(8'd5, 4'b0010, 1'b1); model_yes(1, 4);
        maxuser = 3'd2; jian = 4'd3;
        player = 4'b0110; step(1); player = 4'b0000;
        exp_foul = foul_on ? 4'b0010 : 4'b0000;
        if (foul_on) model_no(1, 3);
        checks++; if (foul !== exp_foul || scores !== model_scores()) begin errors++; $display("[TB] FAIL foul_masked got foul=%b scores=%h exp %b/%h", foul, scores, exp_foul, model_scores()); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_simultaneous();
        test_saturation();
        test_maxuser_expiry();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_foul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
